// File: rtl/wb_sram_bridge.sv
// wb_sram_bridge: Wishbone classic slave to registered single-port SRAM command bridge.
module wb_sram_bridge #(
    parameter int MEM_AW   = 7,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [31:0]       s_wb_dat_i,
    input  logic [8:0]        s_wb_adr_i,
    input  logic [3:0]        s_wb_sel_i,
    input  logic              s_wb_we_i,
    input  logic              s_wb_cyc_i,
    input  logic              s_wb_stb_i,
    output logic [31:0]       s_wb_dat_o,
    output logic              s_wb_ack_o,
    output logic              mem_csb_o,
    output logic              mem_web_o,
    output logic [3:0]        mem_wmask_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_din_o,
    input  logic [31:0]       mem_dout_i
);
    typedef enum logic [2:0] {IDLE, CMD, RWAIT, ACK, GAP} state_t;
    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d, csb_q, csb_d, web_q, web_d;
    logic [31:0]       dat_q, dat_d, din_q, din_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              unused_adr;
    assign unused_adr = ^s_wb_adr_i[1:0];
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            dat_q   <= '0;
            din_q   <= '0;
            wmask_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            dat_q   <= dat_d;
            din_q   <= din_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        csb_d   = csb_q;
        web_d   = web_q;
        dat_d   = dat_q;
        din_d   = din_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (s_wb_cyc_i && s_wb_stb_i) begin
                state_d = CMD;
                csb_d   = 1'b0;
                web_d   = ~s_wb_we_i;
                addr_d  = s_wb_adr_i[MEM_AW+1:2];
                wmask_d = s_wb_we_i ? s_wb_sel_i : 4'h0;
                din_d   = s_wb_we_i ? s_wb_dat_i : din_q;
            end
            // The SRAM latches the command at the end of CMD, so a write dropped here still lands.
            CMD: begin
                csb_d   = 1'b1;
                web_d   = 1'b1;
                state_d = !s_wb_cyc_i ? IDLE : (!web_q ? ACK : RWAIT);
                ack_d   = s_wb_cyc_i && !web_q;
                cnt_d   = READ_LAT[1:0];
            end
            RWAIT: if (!s_wb_cyc_i) begin
                state_d = IDLE;
            end else if (cnt_q == 2'd1) begin
                dat_d   = mem_dout_i;
                state_d = ACK;
                ack_d   = 1'b1;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
            ACK:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign s_wb_ack_o  = ack_q;
    assign s_wb_dat_o  = dat_q;
    assign mem_csb_o   = csb_q;
    assign mem_web_o   = web_q;
    assign mem_wmask_o = wmask_q;
    assign mem_addr_o  = addr_q;
    assign mem_din_o   = din_q;
endmodule

// File: tb/tb_wb_sram_bridge.sv
// tb_wb_sram_bridge: directed bench with an ack scoreboard for a READ_LAT=1 and a READ_LAT=3 bridge.
module tb_wb_sram_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dat_i;
    logic [8:0]  adr;
    logic [3:0]  sel;
    logic        we, cyc1, cyc2, stb;
    logic [31:0] dat_o1, dat_o2, din1, din2, dout1, dout2;
    logic        ack1, ack2, csb1, csb2, web1, web2;
    logic [3:0]  wmask1, wmask2;
    logic [6:0]  addr1, addr2;
    logic [31:0] m1 [128];
    logic [31:0] m2 [128];
    logic [2:0][31:0] p1, p2;
    typedef struct {
        int          dut;
        logic        rd;
        logic [31:0] dat;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int csb_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) if (!csb1) csb_cnt++;

    wb_sram_bridge #(.MEM_AW(7), .READ_LAT(1)) u1 (
        .clk_i(clk), .rst_n(rst_n), .s_wb_dat_i(dat_i), .s_wb_adr_i(adr), .s_wb_sel_i(sel),
        .s_wb_we_i(we), .s_wb_cyc_i(cyc1), .s_wb_stb_i(stb), .s_wb_dat_o(dat_o1), .s_wb_ack_o(ack1),
        .mem_csb_o(csb1), .mem_web_o(web1), .mem_wmask_o(wmask1), .mem_addr_o(addr1),
        .mem_din_o(din1), .mem_dout_i(dout1));
    wb_sram_bridge #(.MEM_AW(7), .READ_LAT(3)) u2 (
        .clk_i(clk), .rst_n(rst_n), .s_wb_dat_i(dat_i), .s_wb_adr_i(adr), .s_wb_sel_i(sel),
        .s_wb_we_i(we), .s_wb_cyc_i(cyc2), .s_wb_stb_i(stb), .s_wb_dat_o(dat_o2), .s_wb_ack_o(ack2),
        .mem_csb_o(csb2), .mem_web_o(web2), .mem_wmask_o(wmask2), .mem_addr_o(addr2),
        .mem_din_o(din2), .mem_dout_i(dout2));

    // SRAM models: command captured on the edge, read data appears READ_LAT edges later.
    always @(posedge clk) begin
        if (!csb1 && !web1)
            for (int b = 0; b < 4; b++) if (wmask1[b]) m1[addr1][8*b +: 8] <= din1[8*b +: 8];
        if (!csb2 && !web2)
            for (int b = 0; b < 4; b++) if (wmask2[b]) m2[addr2][8*b +: 8] <= din2[8*b +: 8];
        p1 <= {p1[1:0], (!csb1 && web1) ? m1[addr1] : 32'h0};
        p2 <= {p2[1:0], (!csb2 && web2) ? m2[addr2] : 32'h0};
    end
    assign dout1 = p1[0];
    assign dout2 = p2[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (d == 0 ? ack1 : ack2) begin
                chk("ack_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("ack_dut", d, mon_e.dut);
                    chk("ack_cycle", cyc_n, mon_e.cyc);
                    if (mon_e.rd) chk("rd_data", d == 0 ? dat_o1 : dat_o2, mon_e.dat);
                end
            end
        end
    end

    task automatic xfer(input int d, input logic w, input logic [8:0] a, input logic [31:0] data,
                        input logic [3:0] s, input logic [31:0] exp_rd, input bit b2b);
        exp_t e;
        int   n = 0;
        we = w; adr = a; dat_i = data; sel = s; stb = 1'b1;
        if (d == 0) cyc1 = 1'b1; else cyc2 = 1'b1;
        e.dut = d;
        e.rd  = !w;
        e.dat = exp_rd;
        e.cyc = cyc_n + (b2b ? 1 : 0) + 2 + (w ? 0 : (d == 0 ? 1 : 3));
        sb.push_back(e);
        if (d == 0) begin
            repeat (b2b ? 3 : 2) @(negedge clk);
            chk("pin_csb", 32'(csb1), 32'd0);
            chk("pin_web", 32'(web1), 32'(!w));
            chk("pin_addr", 32'(addr1), 32'(a[8:2]));
            chk("pin_wmask", 32'(wmask1), 32'(w ? s : 4'h0));
            if (w) chk("pin_din", din1, data);
        end
        while (!(d == 0 ? ack1 : ack2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_wait", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        cyc1 = 1'b0; cyc2 = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cyc1 = 1'b0; cyc2 = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_i = '0; sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack1), 32'd0);
        chk("rst_dat", dat_o1, 32'd0);
        chk("rst_csb", 32'(csb1), 32'd1);
        chk("rst_web", 32'(web1), 32'd1);
        chk("rst_wmask", 32'(wmask1), 32'd0);
        chk("rst_addr", 32'(addr1), 32'd0);
        chk("rst_din", din1, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1, 9'h010, 32'hDEADBEEF, 4'hF, 0, 0); bus_idle();
        xfer(0, 0, 9'h010, 0, 4'hF, 32'hDEADBEEF, 0); bus_idle();
        xfer(0, 1, 9'h020, 32'h11223344, 4'hF, 0, 0); bus_idle();
        xfer(0, 1, 9'h020, 32'h000000AA, 4'h1, 0, 0); bus_idle();
        xfer(0, 0, 9'h020, 0, 4'hF, 32'h112233AA, 0); bus_idle();
        xfer(0, 1, 9'h020, 32'hFFFFFFFF, 4'h0, 0, 0); bus_idle();
        xfer(0, 0, 9'h020, 0, 4'hF, 32'h112233AA, 0); bus_idle();
        xfer(0, 1, 9'h030, 32'hA5A5A5A5, 4'hF, 0, 0);
        xfer(0, 1, 9'h034, 32'h5A5A5A5A, 4'hF, 0, 1); bus_idle();
        xfer(0, 0, 9'h030, 0, 4'hF, 32'hA5A5A5A5, 0); bus_idle();
        xfer(0, 0, 9'h034, 0, 4'hF, 32'h5A5A5A5A, 0); bus_idle();
        // Strobe held through the ack and gap cycles must yield a single command.
        csb_cnt = 0;
        xfer(0, 1, 9'h040, 32'hCAFEF00D, 4'hF, 0, 0);
        @(posedge clk); #1;
        bus_idle();
        repeat (6) @(negedge clk);
        chk("held_csb_pulses", csb_cnt, 1);
        @(posedge clk); #1;
        we = 1'b0; adr = 9'h010; stb = 1'b1; cyc1 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc1 = 1'b0; stb = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_dat_hold", dat_o1, 32'h5A5A5A5A);
        @(posedge clk); #1;
        xfer(0, 0, 9'h040, 0, 4'hF, 32'hCAFEF00D, 0); bus_idle();
        xfer(1, 1, 9'h050, 32'h87654321, 4'hF, 0, 0); bus_idle();
        xfer(1, 0, 9'h050, 0, 4'hF, 32'h87654321, 0); bus_idle();
        we = 1'b0; adr = 9'h020; stb = 1'b1; cyc1 = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_ack", 32'(ack1), 32'd0);
        chk("rstmid_csb", 32'(csb1), 32'd1);
        chk("rstmid_dat", dat_o1, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_idle();
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        xfer(0, 0, 9'h020, 0, 4'hF, 32'h112233AA, 0); bus_idle();
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_sram_bridge.md
# wb_sram_bridge

Wishbone classic slave that sits on slave port 0 of the interconnect, downstream of it, and converts its single-word requests into the registered command interface of the on-chip 32-bit OpenRAM-style SRAM macro. The block sequences each request through a small state machine, waits a configurable read latency, captures read data and returns exactly one ack per request. It forces one idle cycle after every ack so that a request the master is still holding is never accepted twice.

## Interface
- MEM_AW, 7: SRAM word-address width. Word index is s_wb_adr_i[MEM_AW+1:2]; address bits above MEM_AW+1 are ignored and alias.
- READ_LAT, 1: SRAM clock edges from command capture to valid mem_dout_i. Legal range 1..3.

- clk_i  in  1  single block clock; every register uses it.
- rst_n  in  1  reset, synchronous, active-low.
- s_wb_dat_i  in  32  write data.
- s_wb_adr_i  in  9  byte address. Bits [1:0] are ignored.
- s_wb_sel_i  in  4  byte enables.
- s_wb_we_i  in  1  1 = write, 0 = read.
- s_wb_cyc_i  in  1  bus cycle.
- s_wb_stb_i  in  1  strobe.
- s_wb_dat_o  out  32  read data.
- s_wb_ack_o  out  1  one-cycle acknowledge.
- mem_csb_o  out  1  SRAM chip select, active-low.
- mem_web_o  out  1  SRAM write enable, active-low.
- mem_wmask_o  out  4  SRAM byte write mask.
- mem_addr_o  out  MEM_AW  SRAM word address.
- mem_din_o  out  32  SRAM write data.
- mem_dout_i  in  32  SRAM read data.

## Operation
- All outputs are registered.
- Reset values:
  - s_wb_ack_o = 0, s_wb_dat_o = 0.
  - mem_csb_o = 1, mem_web_o = 1.
  - mem_wmask_o = 0, mem_addr_o = 0, mem_din_o = 0.
  - State = IDLE.
- States: IDLE, CMD, RWAIT, ACK, GAP.
- IDLE: when cyc & stb, register the command and go to CMD.
  - mem_csb_o ← 0.
  - mem_web_o ← ~we.
  - mem_addr_o ← adr[MEM_AW+1:2].
  - For writes: mem_din_o ← dat, mem_wmask_o ← sel.
  - For reads: mem_wmask_o ← 0.
- CMD: the command is held on the memory pins for exactly one cycle; the SRAM captures it at the end of this cycle. On leaving CMD, mem_csb_o ← 1 and mem_web_o ← 1.
  - Write → ACK.
  - Read → RWAIT with the latency counter loaded to READ_LAT.
- RWAIT: the counter decrements each cycle. In the cycle where it reaches 1, s_wb_dat_o ← mem_dout_i, then go to ACK.
- ACK: s_wb_ack_o = 1 for this cycle only, then GAP.
- GAP: one cycle; stb is ignored. Then IDLE.
- Abort: if cyc is low in CMD or RWAIT, go to IDLE with no ack.
  - A write already presented in CMD still commits to the SRAM.
  - An aborted read leaves s_wb_dat_o unchanged.
- s_wb_dat_o holds the last captured read value until the next read capture. Writes never change it.
- A write with sel = 0 issues mem_wmask_o = 0, so the SRAM is unchanged, and is still acked normally.
- The block has no error path and never stalls indefinitely.

## Timing
- Cycle 0 is the cycle in which IDLE samples cyc & stb.
- Write: memory command active in cycle 1; ack in cycle 2; GAP in cycle 3; next request is accepted in cycle 4 at the earliest.
- Read: memory command active in cycle 1; data captured at the end of cycle 1+READ_LAT; ack with valid s_wb_dat_o in cycle 2+READ_LAT.
  - READ_LAT = 1 gives ack in cycle 3.
  - READ_LAT = 3 gives ack in cycle 5.
- Back-to-back throughput: one write per 4 cycles; one read per 4+READ_LAT cycles.
- Reset is synchronous: rst_n low at a clock edge forces all reset values on that edge, from any state.
  - A command in flight is dropped and no ack is issued.
  - mem_csb_o returns to 1 on that edge.
- If cyc & stb are still high in GAP, the request is not re-accepted. It is accepted again only if still present when IDLE is reached.

## Test plan
- Write 0xDEADBEEF to byte address 0x010 with sel = 0xF → ack in cycle 2, mem_addr_o = 4, mem_wmask_o = 0xF, mem_web_o = 0 for one cycle. A read of 0x010 (READ_LAT = 1) → ack in cycle 3 with s_wb_dat_o = 0xDEADBEEF.
- Byte lane: write 0x000000AA with sel = 0x1 over existing 0x11223344 → a later read returns 0x112233AA. A write with sel = 0 leaves the word unchanged and is still acked.
- READ_LAT = 3 build: read → ack exactly 5 cycles after the request is sampled; no ack earlier.
- Abort: cyc dropped in RWAIT → no ack; s_wb_dat_o keeps its previous value; the next read acks normally.
- Held strobe: master holds cyc/stb for 2 cycles after ack → exactly one ack and one mem_csb_o pulse. Two distinct back-to-back writes → acks 4 cycles apart.
- Reset mid-read: rst_n = 0 in the cycle after the request is sampled → on the next edge ack = 0, mem_csb_o = 1, s_wb_dat_o = 0, state = IDLE, and no ack is produced afterwards.
